// File: rtl/fixed_div_issuer.sv
// rtl/fixed_div_issuer.sv - request FIFO and strobe/valid issuer for one fixed-point divider
// Optional feature macro: DIV_ISSUER_ZERO_CHECK_EN (answer zero divisors locally, no strobe)
module fixed_div_issuer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64,
    parameter int FIXED_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [FIXED_W-1:0] req_a,
    input  logic [FIXED_W-1:0] req_b,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [FIXED_W-1:0] rsp_q,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_err,
    output logic               div_strobe,
    output logic [FIXED_W-1:0] div_a,
    output logic [FIXED_W-1:0] div_b,
    input  logic               div_valid,
    input  logic [FIXED_W-1:0] div_q,
    output logic               busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    logic [FIXED_W-1:0] mem_a   [DEPTH];
    logic [FIXED_W-1:0] mem_b   [DEPTH];
    logic [TAG_W-1:0]   mem_tag [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;

    state_t             state;
    logic [CW-1:0]      tcnt;
    logic [TAG_W-1:0]   cur_tag;

    logic               push;
    logic               pop;
    logic [FIXED_W-1:0] head_a;
    logic [FIXED_W-1:0] head_b;
    logic [TAG_W-1:0]   head_tag;

    assign req_ready = (count != (AW+1)'(DEPTH));
    assign push      = req_valid && req_ready;
    // The response slot must be empty (or emptying this edge) before a new operation starts,
    // so a completed result always has somewhere to land.
    assign pop       = (state == IDLE) && (count != '0) && (!rsp_valid || rsp_ready);
    assign head_a    = mem_a[rd_ptr];
    assign head_b    = mem_b[rd_ptr];
    assign head_tag  = mem_tag[rd_ptr];
    assign busy      = (count != '0) || (state != IDLE);

    // FIFO storage: data needs no reset, validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= req_a;
            mem_b[wr_ptr]   <= req_b;
            mem_tag[wr_ptr] <= req_tag;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue FSM with registered divider and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tcnt       <= '0;
            cur_tag    <= '0;
            div_strobe <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_q      <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            // Drain first; a load later in this block overrides it.
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        div_a   <= head_a;
                        div_b   <= head_b;
                        cur_tag <= head_tag;
                        tcnt    <= '0;
`ifdef DIV_ISSUER_ZERO_CHECK_EN
                        if (head_b == '0) begin
                            // Saturate toward the sign of the dividend.
                            rsp_q     <= head_a[FIXED_W-1] ? {1'b1, {(FIXED_W-1){1'b0}}}
                                                           : {1'b0, {(FIXED_W-1){1'b1}}};
                            rsp_tag   <= head_tag;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= GAP;
                        end else begin
                            div_strobe <= 1'b1;
                            state      <= ISSUE;
                        end
`else
                        div_strobe <= 1'b1;
                        state      <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    if (div_valid) begin
                        rsp_q      <= div_q;
                        rsp_tag    <= cur_tag;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        div_strobe <= 1'b0;
                        state      <= GAP;
                    end else if (tcnt == CW'(TIMEOUT-1)) begin
                        rsp_q      <= '0;
                        rsp_tag    <= cur_tag;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        div_strobe <= 1'b0;
                        state      <= GAP;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                GAP: begin
                    // Guarantees the divider sees strobe low between operations.
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    div_strobe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_div_issuer.sv
// tb/tb_fixed_div_issuer.sv - directed self-checking bench for fixed_div_issuer
module tb_fixed_div_issuer;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_q;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic        div_strobe;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_valid = 1'b0;
    logic [31:0] div_q = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fixed_div_issuer #(.DEPTH(4), .TAG_W(4), .TIMEOUT(64), .FIXED_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .div_strobe(div_strobe), .div_a(div_a), .div_b(div_b),
        .div_valid(div_valid), .div_q(div_q), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Divider model: answers LAT strobe cycles after the rising strobe, Q14 result.
    logic               mdl_en = 1'b1;
    int                 mdl_cnt = 0;
    int                 strobe_cycles = 0;
    int                 strobe_rises = 0;
    logic               prev_strobe = 1'b0;
    logic               gap_chk = 1'b0;
    logic [31:0]        lat_a = '0;
    logic [31:0]        lat_b = '0;
    logic signed [63:0] num;
    logic signed [63:0] den;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            div_valid   = 1'b0;
            mdl_cnt     = 0;
            gap_chk     = 1'b0;
            prev_strobe = 1'b0;
        end else begin
            if (gap_chk) begin
                chk("gap_strobe_low", div_strobe, 1'b0);
                gap_chk = 1'b0;
            end
            if (div_valid) begin
                chk("strobe_drop_after_valid", div_strobe, 1'b0);
                div_valid = 1'b0;
                mdl_cnt   = 0;
                gap_chk   = 1'b1;
            end else if (div_strobe) begin
                strobe_cycles++;
                if (!prev_strobe) begin
                    strobe_rises++;
                    lat_a = div_a;
                    lat_b = div_b;
                end else begin
                    chk("div_a_stable", div_a, lat_a);
                    chk("div_b_stable", div_b, lat_b);
                end
                mdl_cnt++;
                if (mdl_en && mdl_cnt == LAT) begin
                    num = {{32{div_a[31]}}, div_a};
                    num = num <<< 14;
                    den = {{32{div_b[31]}}, div_b};
                    div_q     = (den == 0) ? 32'h1234_5678 : 32'(num / den);
                    div_valid = 1'b1;
                end
            end else begin
                mdl_cnt = 0;
            end
            prev_strobe = div_strobe;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int g = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        while (!req_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("push_ready", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string name, input logic [31:0] q, input logic [3:0] tag,
                           input logic err);
        int g = 0;
        @(negedge clk);
        while (!rsp_valid && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk({name, "_valid"}, rsp_valid, 1'b1);
        chk({name, "_q"}, rsp_q, q);
        chk({name, "_tag"}, rsp_tag, tag);
        chk({name, "_err"}, rsp_err, err);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    int          r0;
    int          s0;
    int          g;
    int          bad;
    logic [31:0] hq;
    logic [3:0]  ht;
    logic        he;

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_q", rsp_q, 32'd0);
        chk("rst_rsp_tag", rsp_tag, 4'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_strobe", div_strobe, 1'b0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", div_b, 32'd0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single request: 2057/7, tag 3
        r0 = strobe_rises;
        s0 = strobe_cycles;
        push(32'd2057 << 14, 32'd7 << 14, 4'd3);
        @(posedge clk);
        #1 chk("strobe_at_e1", div_strobe, 1'b1);
        chk("busy_in_issue", busy, 1'b1);
        get_rsp("single", 32'd4814555, 4'd3, 1'b0);
        chk("single_rises", strobe_rises - r0, 1);
        chk("single_strobe_cycles", strobe_cycles - s0, LAT);

        // Four back-to-back requests
        push(32'd157 << 14, 32'd7 << 14, 4'd0);
        push(32'd2057 << 14, 32'd7 << 14, 4'd1);
        push(32'd1 << 14, 32'd1 << 14, 4'd2);
        push(32'd10 << 14, 32'd4 << 14, 4'd3);
        chk("b2b_ready_after_pop", req_ready, 1'b1);
        get_rsp("b2b0", 32'd367469, 4'd0, 1'b0);
        get_rsp("b2b1", 32'd4814555, 4'd1, 1'b0);
        get_rsp("b2b2", 32'd16384, 4'd2, 1'b0);
        get_rsp("b2b3", 32'd40960, 4'd3, 1'b0);

        // Held response: slot full blocks issue, FIFO fills
        push(32'd157 << 14, 32'd7 << 14, 4'd5);
        g = 0;
        while (!rsp_valid && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("stall_first_valid", rsp_valid, 1'b1);
        push(32'd2057 << 14, 32'd7 << 14, 4'd6);
        push(32'd1 << 14, 32'd1 << 14, 4'd7);
        push(32'd10 << 14, 32'd4 << 14, 4'd8);
        push(32'd157 << 14, 32'd7 << 14, 4'd9);
        chk("fifo_full_ready_low", req_ready, 1'b0);
        hq = rsp_q;
        ht = rsp_tag;
        he = rsp_err;
        r0 = strobe_rises;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_q", rsp_q, hq);
            chk("stall_tag", rsp_tag, ht);
            chk("stall_err", rsp_err, he);
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_no_strobe", div_strobe, 1'b0);
        end
        chk("stall_rises", strobe_rises - r0, 0);
        get_rsp("stall0", 32'd367469, 4'd5, 1'b0);
        get_rsp("stall1", 32'd4814555, 4'd6, 1'b0);
        get_rsp("stall2", 32'd16384, 4'd7, 1'b0);
        get_rsp("stall3", 32'd40960, 4'd8, 1'b0);
        get_rsp("stall4", 32'd367469, 4'd9, 1'b0);

        // Timeout: divider never answers
        mdl_en = 1'b0;
        s0 = strobe_cycles;
        push(32'd10 << 14, 32'd4 << 14, 4'd10);
        get_rsp("timeout", 32'd0, 4'd10, 1'b1);
        chk("timeout_strobe_cycles", strobe_cycles - s0, 64);
        mdl_en = 1'b1;
        push(32'd1 << 14, 32'd1 << 14, 4'd11);
        get_rsp("after_timeout", 32'd16384, 4'd11, 1'b0);

        // Zero divisor, negative dividend
        r0 = strobe_rises;
        push(-(32'd5 << 14), 32'd0, 4'd12);
`ifdef DIV_ISSUER_ZERO_CHECK_EN
        get_rsp("zero_div", 32'h8000_0000, 4'd12, 1'b1);
        chk("zero_div_rises", strobe_rises - r0, 0);
`else
        get_rsp("zero_div", 32'h1234_5678, 4'd12, 1'b0);
        chk("zero_div_rises", strobe_rises - r0, 1);
`endif

        // Reset during ISSUE with two entries queued
        push(32'd157 << 14, 32'd7 << 14, 4'd1);
        push(32'd2057 << 14, 32'd7 << 14, 4'd2);
        push(32'd10 << 14, 32'd4 << 14, 4'd4);
        chk("pre_reset_strobe", div_strobe, 1'b1);
        chk("pre_reset_busy", busy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_strobe", div_strobe, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_req_ready", req_ready, 1'b1);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_div_a", div_a, 32'd0);
        chk("mid_rst_div_b", div_b, 32'd0);
        chk("mid_rst_rsp_q", rsp_q, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid || div_strobe || busy) bad++;
        end
        rsp_ready = 1'b0;
        chk("post_reset_quiet_cycles", bad, 0);
        chk("post_reset_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
